// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-style control FSM for a multicycle RISC-V-like datapath. Walks
//   FETCH -> DECODE -> per-class execute states and drives the datapath
//   strobes/selects from the registered state. Only branch_taken and
//   pc_write in BRANCH depend on a live input (zero).
//
// Parameters
//   MEM_LATENCY  cycles spent in MEM_ACCESS per load/store (1..15)
//
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-high
//   opcode[6:0]   in   instruction[6:0], sampled in DECODE
//   zero          in   ALU zero flag, used in BRANCH
//   stall         in   freeze request: holds state/counter, gates write strobes
//   pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
//   alu_src_b, branch_taken, illegal   out  datapath strobes/selects
//   alu_op[1:0]   out  00 add, 01 subtract, 10 funct-decoded
//   state[3:0]    out  current state encoding (debug)
//   instret[31:0] out  retired-instruction count (only with INSTRET_COUNTER_EN)
//
// Build option
//   INSTRET_COUNTER_EN  when defined, adds the instret port and counter.
module multicycle_control_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       stall,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src_b,
  output logic       branch_taken,
  output logic       illegal,
  output logic [1:0] alu_op,
  output logic [3:0] state
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_ACCESS = 4'd4,
    S_WB_MEM     = 4'd5,
    S_EXEC       = 4'd6,
    S_WB_ALU     = 4'd7,
    S_BRANCH     = 4'd8,
    S_ILLEGAL    = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_count;
  logic [6:0] r_opcode;
  // IDLE lingers for one edge after reset release so that the edge right
  // after deassertion never launches a fetch; FETCH follows on the second.
  logic       r_armed;

  // Next-state logic (ignores stall; the register simply does not load).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (r_armed) w_next = S_FETCH;
      S_FETCH:      w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_SD: w_next = S_MEM_ADDR;
          OP_R, OP_I:   w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:   w_next = S_MEM_ACCESS;
      S_MEM_ACCESS: begin
        if (r_count == 4'd0) w_next = (r_opcode == OP_LD) ? S_WB_MEM : S_FETCH;
      end
      S_WB_MEM:     w_next = S_FETCH;
      S_EXEC:       w_next = S_WB_ALU;
      S_WB_ALU:     w_next = S_FETCH;
      S_BRANCH:     w_next = S_FETCH;
      S_ILLEGAL:    w_next = S_ILLEGAL;
      default:      w_next = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 4'd0;
      r_opcode <= 7'd0;
      r_armed  <= 1'b0;
    end else if (!stall) begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (r_state == S_DECODE) r_opcode <= opcode;
      // Counter is loaded on the way into MEM_ACCESS and counts down there.
      if (r_state == S_MEM_ADDR)
        r_count <= 4'(MEM_LATENCY - 1);
      else if (r_state == S_MEM_ACCESS && r_count != 4'd0)
        r_count <= r_count - 4'd1;
    end
  end

  // Output decode from registered state; stall only gates the write strobes.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_b    = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    alu_op       = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        alu_op    = 2'b00;
      end
      S_MEM_ACCESS: begin
        mem_read  = (r_opcode == OP_LD);
        mem_write = (r_opcode == OP_SD);
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_op    = 2'b10;
        alu_src_b = (r_opcode == OP_I);
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        alu_src_b = (r_opcode == OP_I);
      end
      S_BRANCH: begin
        alu_op       = 2'b01;
        branch_taken = zero;
        pc_write     = zero;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    if (stall) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign state = r_state;

`ifdef INSTRET_COUNTER_EN
  logic [31:0] r_instret;
  logic        w_retire;

  // An instruction retires on any unstalled edge that lands back in FETCH
  // from a completing state (MEM_ACCESS only reaches FETCH for a store).
  assign w_retire = !stall && (w_next == S_FETCH) &&
                    (r_state == S_WB_MEM || r_state == S_WB_ALU ||
                     r_state == S_BRANCH || r_state == S_MEM_ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

endmodule
